// File: rtl/encoder8_to_3_seq.sv
// Sequential 8-to-3 encoder: takes a multi-hot rule-fire vector and emits the
// index of each set bit, one per valid/ready handshake, in priority order.
module encoder8_to_3_seq #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_vec,
    output logic       in_ready,
    output logic       out_valid,
    output logic [2:0] out_idx,
    output logic       out_last,
    input  logic       out_ready,
    output logic [3:0] count,
    output logic       none_pulse
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t     state, state_nxt;
    logic [7:0] pending, pending_nxt;
    logic       accept;

    function automatic logic [2:0] pick_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        if (LSB_FIRST) begin
            for (int i = 7; i >= 0; i--) begin
                if (v[i]) idx = 3'(i);
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (v[i]) idx = 3'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // pending is zero in IDLE, so out_idx/out_last read back as zero there.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == SCAN);
    assign out_idx   = pick_idx(pending);
    assign out_last  = (pending != 8'd0) && ((pending & (pending - 8'd1)) == 8'd0);

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (in_vec != 8'd0) begin
                        pending_nxt = in_vec;
                        state_nxt   = SCAN;
                    end
                end
            end
            SCAN: begin
                if (out_ready) begin
                    pending_nxt = pending & ~(8'd1 << out_idx);
                    if (out_last) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pending    <= 8'd0;
            count      <= 4'd0;
            none_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            pending    <= pending_nxt;
            none_pulse <= accept && (in_vec == 8'd0);
            if (accept) count <= popcount(in_vec);
        end
    end

endmodule

// File: tb/tb_encoder8_to_3_seq.sv
// Directed and randomized round-trip bench for encoder8_to_3_seq; one instance
// per scan order, both fed the same stimulus so they run in lockstep.
module tb_encoder8_to_3_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_vec;
    logic       out_ready;

    logic       l_in_ready, l_out_valid, l_out_last, l_none;
    logic [2:0] l_out_idx;
    logic [3:0] l_count;
    logic       m_in_ready, m_out_valid, m_out_last, m_none;
    logic [2:0] m_out_idx;
    logic [3:0] m_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    encoder8_to_3_seq #(.LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_vec(in_vec),
        .in_ready(l_in_ready), .out_valid(l_out_valid), .out_idx(l_out_idx),
        .out_last(l_out_last), .out_ready(out_ready), .count(l_count),
        .none_pulse(l_none)
    );

    encoder8_to_3_seq #(.LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_vec(in_vec),
        .in_ready(m_in_ready), .out_valid(m_out_valid), .out_idx(m_out_idx),
        .out_last(m_out_last), .out_ready(out_ready), .count(m_count),
        .none_pulse(m_none)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic int highest(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) if (v[i]) return i;
        return 0;
    endfunction

    task automatic accept_vec(input logic [7:0] v);
        in_vec   = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    int         seq_l [4] = '{1, 2, 5, 7};
    int         seq_m [4] = '{7, 5, 2, 1};
    logic [7:0] vec, rem_l, rem_m;
    int         hs, cyc;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_vec = 8'h00; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_out_valid", l_out_valid, 0);
        check("rst_in_ready", l_in_ready, 1);
        check("rst_count", l_count, 0);
        check("rst_none", l_none, 0);
        check("rst_idx", l_out_idx, 0);
        check("rst_last", l_out_last, 0);

        // Streaming 8'b1010_0110
        accept_vec(8'hA6);
        check("str_count", l_count, 4);
        check("str_in_ready", l_in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            check("str_valid", l_out_valid, 1);
            check("str_idx_l", l_out_idx, seq_l[i]);
            check("str_last_l", l_out_last, (i == 3));
            check("str_idx_m", m_out_idx, seq_m[i]);
            check("str_last_m", m_out_last, (i == 3));
            tick();
        end
        check("str_done_valid", l_out_valid, 0);
        check("str_done_ready", l_in_ready, 1);

        // Backpressure 8'h81
        out_ready = 1'b0;
        accept_vec(8'h81);
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", l_out_valid, 1);
            check("bp_idx", l_out_idx, 0);
            check("bp_last", l_out_last, 0);
            tick();
        end
        out_ready = 1'b1;
        check("bp_rel_idx0", l_out_idx, 0);
        tick();
        check("bp_idx7", l_out_idx, 7);
        check("bp_last7", l_out_last, 1);
        tick();
        check("bp_done_valid", l_out_valid, 0);

        // Zero vector
        accept_vec(8'h00);
        check("zero_none", l_none, 1);
        check("zero_valid", l_out_valid, 0);
        check("zero_count", l_count, 0);
        check("zero_ready", l_in_ready, 1);
        tick();
        check("zero_none_clr", l_none, 0);
        check("zero_valid2", l_out_valid, 0);

        // 8'hFF with in_valid held during SCAN
        accept_vec(8'hFF);
        in_vec   = 8'h0F;
        in_valid = 1'b1;
        check("ff_count", m_count, 8);
        for (int i = 0; i < 8; i++) begin
            check("ff_in_ready", m_in_ready, 0);
            check("ff_idx_m", m_out_idx, 7 - i);
            check("ff_last_m", m_out_last, (i == 7));
            check("ff_idx_l", l_out_idx, i);
            if (i == 7) in_valid = 1'b0;
            tick();
        end
        check("ff_count_hold", m_count, 8);
        check("ff_done_valid", m_out_valid, 0);

        // Reset mid-SCAN
        accept_vec(8'hFF);
        tick(); tick(); tick();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("mrst_valid", l_out_valid, 0);
        check("mrst_ready", l_in_ready, 1);
        check("mrst_count", l_count, 0);
        accept_vec(8'h01);
        check("mrst_idx", l_out_idx, 0);
        check("mrst_last", l_out_last, 1);
        check("mrst_idx_m", m_out_idx, 0);
        tick();
        check("mrst_done", l_out_valid, 0);

        // Random round-trip
        for (int n = 0; n < 1000; n++) begin
            vec = 8'($urandom);
            accept_vec(vec);
            check("rt_count_l", l_count, $countones(vec));
            check("rt_count_m", m_count, $countones(vec));
            if (vec == 8'd0) begin
                check("rt_none", l_none, 1);
                continue;
            end
            rem_l = vec; rem_m = vec; hs = 0; cyc = 0;
            while (rem_l != 8'd0 && cyc < 80) begin
                out_ready = 1'($urandom_range(0, 1));
                check("rt_valid", l_out_valid, 1);
                check("rt_idx_l", l_out_idx, lowest(rem_l));
                check("rt_last_l", l_out_last, ($countones(rem_l) == 1));
                check("rt_idx_m", m_out_idx, highest(rem_m));
                if (out_ready) begin
                    rem_l[l_out_idx] = 1'b0;
                    rem_m[m_out_idx] = 1'b0;
                    hs++;
                end
                tick();
                cyc++;
            end
            check("rt_timeout", (cyc < 80), 1);
            check("rt_recon_l", rem_l, 0);
            check("rt_recon_m", rem_m, 0);
            check("rt_hs", hs, l_count);
            check("rt_idle", l_in_ready, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/encoder8_to_3_seq.md
Name: encoder8_to_3_seq

Overview:
Sequential 8-to-3 encoder, the inverse of the 3-bit-to-one-hot decoder used in the fuzzy rule path.
- Accepts an 8-bit multi-hot vector of fired rule lines.
- Emits the 3-bit index of each set bit, one per handshake, in priority order.
- Sits between the rule-fire stage and the per-rule consequent/defuzzifier accumulator, which handles one rule index at a time.

Parameters:
LSB_FIRST, 1, 1: scan from bit 0 upward (bit 0 highest priority); 0: scan from bit 7 downward.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  in_vec is valid
in_vec  input  8  multi-hot rule-fire vector; bit i = rule i fired
in_ready  output  1  block can accept a vector this cycle
out_valid  output  1  out_idx is valid
out_idx  output  3  binary index of current highest-priority pending bit
out_last  output  1  out_idx is the final pending bit of this vector
out_ready  input  1  downstream accepts out_idx this cycle
count  output  4  popcount of the most recently accepted vector (0..8)
none_pulse  output  1  one-cycle pulse: accepted vector was all-zero

Behaviour:
- Reset: synchronous on rst=1 at a rising edge.
  - State=IDLE, pending=0, out_valid=0, out_idx=0, out_last=0, count=0, none_pulse=0, in_ready=1.
  - Reset mid-SCAN discards pending bits; no further outputs for that vector.
- State machine: two states, IDLE and SCAN.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept on in_valid & in_ready at edge k: count <= popcount(in_vec).
  - in_vec != 0: pending <= in_vec; go to SCAN.
  - in_vec == 0: stay IDLE; none_pulse=1 for cycle k+1 only; no index emitted.
- SCAN:
  - in_ready=0; in_valid is ignored (no overlap, no input buffering).
  - out_valid=1 from cycle k+1, so first-index latency is 1 cycle after accept.
  - out_idx = lowest set bit of pending when LSB_FIRST=1, else highest set bit; combinational from the pending register.
  - out_last=1 when pending has exactly one bit set.
  - On out_valid & out_ready: clear the bit at out_idx in pending.
    - If out_last: go to IDLE; in_ready=1 next cycle.
    - Otherwise stay in SCAN; next index is presented the following cycle.
  - out_ready=0: out_idx, out_last and pending hold stable (standard valid/ready; valid never drops without a handshake).
- Throughput:
  - One index per cycle while out_ready=1.
  - Vector with n set bits occupies 1 accept cycle + n output cycles.
  - Next accept is possible on the cycle after the last handshake. No same-cycle last-handshake/accept bypass.
- count holds until the next accept or reset.
- Invariant: OR of decoded one-hots of all emitted out_idx for one vector equals the accepted in_vec; each index is emitted exactly once.
- out_idx is a 3-bit unsigned value; no wrap is possible; popcount needs 4 bits (max 8).

Test Plan:
- Reset: rst=1 for 2 cycles mid-SCAN (in_vec=8'hFF accepted, 3 indices taken) -> next cycle out_valid=0, in_ready=1, count=0; new vector 8'h01 then yields out_idx=0, out_last=1.
- Streaming, LSB_FIRST=1, out_ready=1: in_vec=8'b1010_0110 -> out_idx 1,2,5,7 on consecutive cycles starting 1 cycle after accept; out_last only with 7; count=4; in_ready=1 the cycle after 7.
- Backpressure: in_vec=8'h81, out_ready low 3 cycles -> out_idx=0 held stable with out_valid=1; on release emits 0 then 7 (out_last=1).
- Zero vector: in_vec=8'h00 accepted -> none_pulse=1 for exactly one cycle, out_valid stays 0, count=0, in_ready remains 1.
- LSB_FIRST=0: in_vec=8'hFF -> out_idx 7,6,...,0, out_last with 0, count=8; in_valid asserted during SCAN is ignored (in_ready=0).
- Round-trip: feed every out_idx through the 3-to-8 decoder and OR the results, for 1000 random vectors with random out_ready -> reconstruction equals in_vec and the number of handshakes equals count.
